// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage.
// Holds the IF/ID bundle, the NOP encoding and the default reset PC.
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h00000000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       '0,
        pc_plus4: '0,
        valid:    1'b0
    };

    // Clear the byte-offset bits so fetch stays word aligned.
    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] a
    );
        return a & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_stage_flopenrc.sv
// Resettable register with enable and synchronous clear.
// Async reset wins, then clear, then enable.
module flopenrc #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Register update: reset, then clear, then load on enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register and IF/ID pipeline register.
// Define FETCH_PERF_EN to add the FetchCount load counter output.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] InstrF,
`ifdef FETCH_PERF_EN
    output logic [XLEN-1:0] FetchCount,
`endif
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    logic [XLEN-1:0] PCPlus4F;
    logic [XLEN-1:0] PCNextF;
    logic            pc_en;
    logic            load_d;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    // Next-PC selection; a redirect beats a fetch stall.
    always_comb begin
        PCPlus4F = PCF + XLEN'(4);
        PCNextF  = PCPlus4F;
        pc_en    = ~StallF | PCSrcE;
        if (PCSrcE) begin
            PCNextF = word_align(PCTargetE);
        end
    end

    flopenrc #(
        .WIDTH  (XLEN),
        .RST_VAL(RESET_PC),
        .CLR_VAL(RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .reset(reset),
        .en   (pc_en),
        .clr  (1'b0),
        .d    (PCNextF),
        .q    (PCF)
    );

    // Bundle the fetched instruction for decode.
    always_comb begin
        if_id_d          = IF_ID_BUBBLE;
        if_id_d.instr    = InstrF;
        if_id_d.pc       = PCF;
        if_id_d.pc_plus4 = PCPlus4F;
        if_id_d.valid    = 1'b1;
        load_d           = ~FlushD & ~StallD;
    end

    flopenrc #(
        .WIDTH  ($bits(if_id_t)),
        .RST_VAL(IF_ID_BUBBLE),
        .CLR_VAL(IF_ID_BUBBLE)
    ) u_if_id_reg (
        .clk  (clk),
        .reset(reset),
        .en   (~StallD),
        .clr  (FlushD),
        .d    (if_id_d),
        .q    (if_id_q)
    );

    assign InstrD   = if_id_q.instr;
    assign PCD      = if_id_q.pc;
    assign PCPlus4D = if_id_q.pc_plus4;
    assign ValidD   = if_id_q.valid;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] fetch_count_next;

    // Count real IF/ID loads; wraps naturally at 2^32.
    always_comb begin
        fetch_count_next = FetchCount + XLEN'(1);
    end

    flopenrc #(
        .WIDTH  (XLEN),
        .RST_VAL('0),
        .CLR_VAL('0)
    ) u_fetch_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (load_d),
        .clr  (1'b0),
        .d    (fetch_count_next),
        .q    (FetchCount)
    );
`else
    logic unused_load_d;
    assign unused_load_d = load_d;
`endif

endmodule
